// File: rtl/wb_commit_checker.sv
// Writeback checker: compares committed register writes, in order, against a preloaded queue of expected writes.
// Latency: a checked writeback updates counters/err fields/state at the edge ending its cycle (visible next cycle).
// Backpressure: exp_ready is high only in IDLE while the queue has room; writebacks cannot be stalled.
module wb_commit_checker #(
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 10000,
    parameter int CNT_W     = 16,
    parameter int IGNORE_X0 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [RA_W-1:0]  exp_rd,
    input  logic [XLEN-1:0]  exp_data,
    input  logic             start,
    input  logic             clear,
    input  logic             wb_reg_write,
    input  logic [RA_W-1:0]  wb_rd_addr,
    input  logic [XLEN-1:0]  wb_write_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timed_out,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [CNT_W-1:0] extra_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic             err_valid,
    output logic [RA_W-1:0]  err_rd,
    output logic [XLEN-1:0]  err_exp,
    output logic [XLEN-1:0]  err_got
);

    localparam int AW = $clog2(DEPTH);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam logic [AW:0] Q_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] Q_ONE  = (AW + 1)'(1);
    // If TIMEOUT-1 does not fit in the counter, the saturated count can never reach it.
    localparam bit               TO_FITS = ((TIMEOUT - 1) >> CNT_W) == 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [RA_W-1:0]   mem_rd   [DEPTH];
    logic [XLEN-1:0]   mem_data [DEPTH];
    logic [CNT_W-1:0]  match_q;
    logic [CNT_W-1:0]  mismatch_q;
    logic [CNT_W-1:0]  extra_q;
    logic [CNT_W-1:0]  cycle_q;
    logic              timed_out_q;
    logic              err_valid_q;
    logic [RA_W-1:0]   err_rd_q;
    logic [XLEN-1:0]   err_exp_q;
    logic [XLEN-1:0]   err_got_q;

    logic [AW:0]       q_cnt;
    logic              q_full;
    logic              chk_evt;
    logic              push;
    logic              pop;
    logic              last_pop;
    logic              timeout_hit;
    logic [RA_W-1:0]   head_rd;
    logic [XLEN-1:0]   head_data;
    logic              head_match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Queue occupancy, event qualification and compare against the queue head.
    always_comb begin
        q_cnt       = wr_ptr_q - rd_ptr_q;
        q_full      = (q_cnt == Q_FULL);
        chk_evt     = wb_reg_write && ((IGNORE_X0 == 0) || (wb_rd_addr != '0));
        push        = (state_q == S_IDLE) && exp_valid && !q_full;
        pop         = (state_q == S_RUN) && chk_evt;
        last_pop    = pop && (q_cnt == Q_ONE);
        timeout_hit = (state_q == S_RUN) && TO_FITS && (cycle_q == TO_LAST);
        head_rd     = mem_rd[rd_ptr_q[AW-1:0]];
        head_data   = mem_data[rd_ptr_q[AW-1:0]];
        head_match  = (wb_rd_addr == head_rd) && (wb_write_data == head_data);
    end

    // Expected-write storage; no reset needed because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_q[AW-1:0]]   <= exp_rd;
            mem_data[wr_ptr_q[AW-1:0]] <= exp_data;
        end
    end

    // Control FSM with queue pointers, counters and first-error capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            match_q     <= '0;
            mismatch_q  <= '0;
            extra_q     <= '0;
            cycle_q     <= '0;
            timed_out_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_rd_q    <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + Q_ONE;
                    end
                    // A same-cycle push counts toward the empty test.
                    if (start) begin
                        state_q <= ((q_cnt != '0) || push) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    cycle_q <= sat_inc(cycle_q);
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + Q_ONE;
                        if (head_match) begin
                            match_q <= sat_inc(match_q);
                        end else begin
                            mismatch_q <= sat_inc(mismatch_q);
                            if (!err_valid_q) begin
                                err_valid_q <= 1'b1;
                                err_rd_q    <= (wb_rd_addr != head_rd) ? wb_rd_addr : head_rd;
                                err_exp_q   <= head_data;
                                err_got_q   <= wb_write_data;
                            end
                        end
                    end
                    // Draining the queue takes priority over a coincident watchdog expiry.
                    if (last_pop) begin
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        state_q     <= S_DONE;
                        timed_out_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (chk_evt) begin
                        extra_q <= sat_inc(extra_q);
                    end
                    if (clear) begin
                        state_q     <= S_IDLE;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        match_q     <= '0;
                        mismatch_q  <= '0;
                        extra_q     <= '0;
                        cycle_q     <= '0;
                        timed_out_q <= 1'b0;
                        err_valid_q <= 1'b0;
                        err_rd_q    <= '0;
                        err_exp_q   <= '0;
                        err_got_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        exp_ready      = (state_q == S_IDLE) && !q_full;
        busy           = (state_q == S_RUN);
        done           = (state_q == S_DONE);
        pass           = done && (mismatch_q == '0) && (extra_q == '0) && !timed_out_q;
        fail           = done && !pass;
        timed_out      = timed_out_q;
        match_count    = match_q;
        mismatch_count = mismatch_q;
        extra_count    = extra_q;
        cycle_count    = cycle_q;
        err_valid      = err_valid_q;
        err_rd         = err_rd_q;
        err_exp        = err_exp_q;
        err_got        = err_got_q;
    end

endmodule

// File: tb/tb_wb_commit_checker.sv
// Bench for wb_commit_checker: directed and randomized program runs checked against an in-order queue model.
// Latency: inputs driven just after the falling edge, outputs sampled one falling edge later.
// Backpressure: exp_ready is checked against the model's queue occupancy during loading.
module tb_wb_commit_checker;

    localparam int XLEN    = 32;
    localparam int RA_W    = 5;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 50;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             exp_valid;
    logic             exp_ready;
    logic [RA_W-1:0]  exp_rd;
    logic [XLEN-1:0]  exp_data;
    logic             start;
    logic             clear;
    logic             wb_reg_write;
    logic [RA_W-1:0]  wb_rd_addr;
    logic [XLEN-1:0]  wb_write_data;
    logic             busy, done, pass, fail, timed_out, err_valid;
    logic [CNT_W-1:0] match_count, mismatch_count, extra_count, cycle_count;
    logic [RA_W-1:0]  err_rd;
    logic [XLEN-1:0]  err_exp, err_got;

    wb_commit_checker #(
        .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .IGNORE_X0(1)
    ) dut (
        .clk(clk), .reset(reset),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rd(exp_rd), .exp_data(exp_data),
        .start(start), .clear(clear),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_write_data(wb_write_data),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timed_out(timed_out),
        .match_count(match_count), .mismatch_count(mismatch_count),
        .extra_count(extra_count), .cycle_count(cycle_count),
        .err_valid(err_valid), .err_rd(err_rd), .err_exp(err_exp), .err_got(err_got)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Program under test: expected writes offered, and the per-cycle writeback trace during RUN.
    logic [RA_W-1:0] e_rd[$];
    logic [XLEN-1:0] e_data[$];
    logic            t_en[$];
    logic [RA_W-1:0] t_rd[$];
    logic [XLEN-1:0] t_data[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic clear_prog();
        e_rd.delete(); e_data.delete();
        t_en.delete(); t_rd.delete(); t_data.delete();
    endtask

    task automatic add_exp(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d);
        e_rd.push_back(rd); e_data.push_back(d);
    endtask

    task automatic add_wb(input logic en, input logic [RA_W-1:0] rd, input logic [XLEN-1:0] d);
        t_en.push_back(en); t_rd.push_back(rd); t_data.push_back(d);
    endtask

    task automatic gen_rand(input int n);
        int k;
        int r;
        clear_prog();
        for (int i = 0; i < n; i++) add_exp(RA_W'($urandom_range(1, 31)), $urandom);
        k = 0;
        for (int c = 0; c < 3 * n + 4; c++) begin
            r = $urandom_range(0, 9);
            if (k >= n || r < 2) add_wb(1'b0, RA_W'($urandom_range(0, 31)), $urandom);
            else if (r == 2) add_wb(1'b1, '0, $urandom);
            else if (r == 3) begin
                if ($urandom_range(0, 1) == 1) add_wb(1'b1, RA_W'((e_rd[k] % 31) + 1), e_data[k]);
                else add_wb(1'b1, e_rd[k], e_data[k] ^ (32'h1 << $urandom_range(0, 31)));
                k++;
            end else begin
                add_wb(1'b1, e_rd[k], e_data[k]);
                k++;
            end
        end
    endtask

    // Load, start, replay the trace, compare with the model, then extra writes and clear.
    task automatic run_case(input string name, input int n_extra);
        int stored, pos, m, mm, dn;
        bit to, ev, exp_pass;
        logic [RA_W-1:0] x_rd;
        logic [XLEN-1:0] x_exp, x_got;
        stored = 0;
        for (int i = 0; i < e_rd.size(); i++) begin
            exp_valid = 1'b1; exp_rd = e_rd[i]; exp_data = e_data[i];
            wb_reg_write = 1'b1; wb_rd_addr = RA_W'($urandom_range(1, 31)); wb_write_data = $urandom;
            #1;
            chk({name, ".exp_ready"}, exp_ready, stored < DEPTH);
            @(negedge clk);
            if (stored < DEPTH) stored++;
        end
        exp_valid = 1'b0;
        start = 1'b1;
        wb_reg_write = 1'b1; wb_rd_addr = RA_W'($urandom_range(1, 31)); wb_write_data = $urandom;
        @(negedge clk);
        start = 1'b0;

        // Reference: walk the trace popping the expected list in order.
        pos = 0; m = 0; mm = 0; dn = -1; to = 1'b0; ev = 1'b0;
        x_rd = '0; x_exp = '0; x_got = '0;
        if (stored > 0) begin
            for (int i = 0; i < TIMEOUT; i++) begin
                if (i < t_en.size() && t_en[i] && t_rd[i] != '0) begin
                    if (t_rd[i] == e_rd[pos] && t_data[i] == e_data[pos]) m++;
                    else begin
                        mm++;
                        if (!ev) begin
                            ev = 1'b1;
                            x_rd = (t_rd[i] != e_rd[pos]) ? t_rd[i] : e_rd[pos];
                            x_exp = e_data[pos]; x_got = t_data[i];
                        end
                    end
                    pos++;
                    if (pos == stored) begin dn = i; break; end
                end
                if (i == TIMEOUT - 1) begin dn = i; to = 1'b1; break; end
            end
        end
        exp_pass = (mm == 0) && !to;

        for (int i = 0; i <= dn; i++) begin
            chk({name, ".busy"}, busy, 1);
            if (i < t_en.size()) begin
                wb_reg_write = t_en[i]; wb_rd_addr = t_rd[i]; wb_write_data = t_data[i];
            end else wb_reg_write = 1'b0;
            @(negedge clk);
        end
        wb_reg_write = 1'b0;
        chk({name, ".done"}, done, 1);
        chk({name, ".busy_off"}, busy, 0);
        chk({name, ".pass"}, pass, exp_pass);
        chk({name, ".fail"}, fail, !exp_pass);
        chk({name, ".match"}, match_count, m);
        chk({name, ".mismatch"}, mismatch_count, mm);
        chk({name, ".timed_out"}, timed_out, to);
        chk({name, ".cycle_count"}, cycle_count, dn + 1);
        chk({name, ".err_valid"}, err_valid, ev);
        if (ev) begin
            chk({name, ".err_rd"}, err_rd, x_rd);
            chk({name, ".err_exp"}, err_exp, x_exp);
            chk({name, ".err_got"}, err_got, x_got);
        end

        for (int j = 0; j < n_extra; j++) begin
            wb_reg_write = 1'b1; wb_rd_addr = RA_W'($urandom_range(1, 31)); wb_write_data = $urandom;
            @(negedge clk);
            wb_rd_addr = '0;
            @(negedge clk);
        end
        wb_reg_write = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ".extra"}, extra_count, n_extra);
        chk({name, ".done_hold"}, done, 1);
        chk({name, ".pass_after"}, pass, exp_pass && n_extra == 0);
        chk({name, ".fail_after"}, fail, !(exp_pass && n_extra == 0));

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({name, ".clr_done"}, done, 0);
        chk({name, ".clr_ready"}, exp_ready, 1);
        chk({name, ".clr_counts"}, {match_count, mismatch_count}, 0);
        chk({name, ".clr_extra_cyc"}, {extra_count, cycle_count}, 0);
        chk({name, ".clr_flags"}, {err_valid, timed_out, pass, fail}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; exp_valid = 1'b0; exp_rd = '0; exp_data = '0; start = 1'b0; clear = 1'b0;
        wb_reg_write = 1'b0; wb_rd_addr = '0; wb_write_data = '0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("reset.ready", exp_ready, 1);
        chk("reset.state", {busy, done, pass, fail, timed_out, err_valid}, 0);
        chk("reset.counts", {match_count, mismatch_count, extra_count, cycle_count}, 0);
        chk("reset.err", {err_rd, err_exp, err_got}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Three matching writes back to back.
        clear_prog();
        add_exp(1, 5); add_exp(2, 3); add_exp(3, 8);
        add_wb(1, 1, 5); add_wb(1, 2, 3); add_wb(1, 3, 8);
        run_case("match3", 0);

        // Data mismatch on the last write, then one extra write.
        clear_prog();
        add_exp(1, 5); add_exp(2, 3); add_exp(3, 8);
        add_wb(1, 1, 5); add_wb(1, 2, 3); add_wb(1, 3, 7);
        run_case("mismatch", 1);

        // Watchdog: one entry, no writebacks.
        clear_prog();
        add_exp(7, 32'h1234);
        run_case("timeout", 0);

        // Final pop in the watchdog's last cycle wins.
        clear_prog();
        add_exp(9, 32'hABCD);
        for (int i = 0; i < TIMEOUT - 1; i++) add_wb(0, 9, 32'hABCD);
        add_wb(1, 9, 32'hABCD);
        run_case("pop_vs_timeout", 0);

        // Seventeen offered, sixteen stored, sixteen matching writebacks.
        clear_prog();
        for (int i = 0; i < 17; i++) add_exp(RA_W'(i % 31 + 1), 32'h100 + i);
        for (int i = 0; i < DEPTH; i++) add_wb(1, e_rd[i], e_data[i]);
        run_case("full", 0);

        // x0 writes interleaved are never checked.
        clear_prog();
        add_exp(4, 40); add_exp(5, 50); add_exp(6, 60);
        add_wb(1, 4, 40); add_wb(1, 0, 32'hDEAD); add_wb(1, 5, 50);
        add_wb(1, 0, 32'hDEAD); add_wb(0, 6, 60); add_wb(1, 6, 60);
        run_case("x0", 0);

        // Start with an empty queue finishes immediately with pass.
        clear_prog();
        run_case("empty", 0);

        // Reset in the middle of a run.
        clear_prog();
        add_exp(1, 5); add_exp(2, 3); add_exp(3, 8);
        for (int i = 0; i < 3; i++) begin
            exp_valid = 1'b1; exp_rd = e_rd[i]; exp_data = e_data[i];
            @(negedge clk);
        end
        exp_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; wb_reg_write = 1'b1; wb_rd_addr = 1; wb_write_data = 5;
        @(negedge clk);
        wb_reg_write = 1'b0;
        chk("midrst.match", match_count, 1);
        chk("midrst.busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("midrst.ready", exp_ready, 1);
        chk("midrst.state", {busy, done, pass, fail, timed_out, err_valid}, 0);
        chk("midrst.counts", {match_count, mismatch_count, extra_count, cycle_count}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_prog();
        add_exp(1, 5); add_exp(2, 3); add_exp(3, 8);
        add_wb(1, 1, 5); add_wb(1, 2, 3); add_wb(1, 3, 8);
        run_case("rerun", 0);

        // Randomized programs.
        for (int r = 0; r < 8; r++) begin
            gen_rand($urandom_range(1, DEPTH));
            run_case($sformatf("rand%0d", r), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_checker.md
# wb_commit_checker

Synthesizable, parametrised writeback checker for pipelined-core test harnesses. Observes the core's register-file writeback port (enable, destination, data) and compares each architectural write, in program order, against a queue of expected writes loaded beforehand. Reports pass/fail, match and mismatch counts, the first error, unexpected extra writes and a watchdog timeout, so a bench or FPGA harness can self-check a program run.

## Interface
Parameters:
- XLEN, 32, data width of a writeback
- RA_W, 5, register address width
- DEPTH, 16, expected-write queue entries (power of two, ≥2)
- TIMEOUT, 10000, maximum cycles spent in RUN before timeout (≥1)
- CNT_W, 16, width of all counters (saturating)
- IGNORE_X0, 1, when 1, writebacks with rd=0 are not checked

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- exp_valid  in  1  expected-write entry offered
- exp_ready  out  1  entry accepted this cycle when exp_valid=1
- exp_rd  in  RA_W  expected destination register
- exp_data  in  XLEN  expected write data
- start  in  1  arm the checker (IDLE only)
- clear  in  1  return to IDLE, flush queue, zero counters (DONE only)
- wb_reg_write  in  1  core writeback enable
- wb_rd_addr  in  RA_W  core writeback destination
- wb_write_data  in  XLEN  core writeback data
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  done, zero mismatches, zero extras, no timeout
- fail  out  1  done and not pass
- timed_out  out  1  RUN ended by watchdog
- match_count, mismatch_count, extra_count  out  CNT_W  event counters
- cycle_count  out  CNT_W  cycles spent in RUN (saturating)
- err_valid  out  1  first-error fields hold data
- err_rd  out  RA_W, err_exp  out  XLEN, err_got  out  XLEN  first mismatch: expected rd, expected data, received data (received rd goes in err_rd if rd differs; expected rd otherwise)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0 except exp_ready=1; queue empty.
- A checked event is a cycle with wb_reg_write=1 and (IGNORE_X0=0 or wb_rd_addr≠0).
- IDLE: exp_ready = queue not full; handshake exp_valid&exp_ready pushes {exp_rd, exp_data}. Checked events are ignored. start=1: queue non-empty → RUN; queue empty → DONE (pass=1). A push and start in the same cycle: the entry is pushed, then the empty/non-empty test includes it.
- RUN: exp_ready=0. Each checked event pops the head and compares rd and data; both equal → match_count+1, else mismatch_count+1 and, if err_valid=0, latch err fields and set err_valid. Pop that empties the queue → DONE. cycle_count increments every RUN cycle; the cycle in which cycle_count reaches TIMEOUT−1 without emptying → DONE, timed_out=1. If the final pop and the timeout coincide, the pop wins (timed_out=0).
- DONE: checked events increment extra_count (forces fail). start ignored. clear=1 → IDLE, queue flushed, all counters, err fields and timed_out zeroed.
- clear in IDLE/RUN ignored. All counters saturate at 2^CNT_W−1.
- Reset mid-RUN: immediate return to IDLE, queue flushed, everything zeroed.

## Timing
- Queue push, compare and state change take effect at the clock edge ending the event cycle; counters, err fields, done/pass visible the next cycle.
- Writeback-to-counter latency: 1 cycle. Final checked event at cycle N → done=1 from cycle N+1.
- start sampled in IDLE at edge E → busy=1 from E; cycle_count=0 in first RUN cycle.
- Back-to-back checked events every cycle are fully supported (one pop per cycle).
- Queue full: exp_ready=0; exp_valid ignored, no overwrite.

## Test plan
- Load (x1,5),(x2,3),(x3,8); start; drive writebacks x1←5, x2←3, x3←8 on consecutive cycles → done one cycle after last, pass=1, match_count=3, mismatch_count=0.
- Same load; drive x3←7 → fail=1, mismatch_count=1, err_valid=1, err_rd=3, err_exp=8, err_got=7; an additional x4←1 afterwards → extra_count=1.
- TIMEOUT=50, one entry loaded, no writebacks → timed_out=1, fail=1, cycle_count=50 when done rises.
- Push 17 entries with DEPTH=16 → exp_ready low after 16th, 17th not stored; run 16 matching writebacks → pass=1, match_count=16.
- IGNORE_X0=1: interleave x0←0xDEAD writebacks among three matching ones → pass=1, match_count=3; writebacks during IDLE not counted.
- Assert reset mid-RUN after one match → all outputs 0, exp_ready=1; reload and rerun → pass=1; clear from DONE → IDLE with zeroed counters.
